// File: rtl/conv_window_sequencer.sv
// Walks a stored 8-bit image in raster order and streams each 3x3 window, one byte per
// single-cycle strobe, to the window-assembly bridge. Define CONV_SEQ_PAD_EN for 1-pixel zero padding.
module conv_window_sequencer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              win_ack,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_STB  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

`ifdef CONV_SEQ_PAD_EN
    // win_row/win_col name the window centre, so every pixel is a centre
    localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);
    localparam logic [7:0] LAST_COL = 8'(IMG_W - 1);
`else
    localparam logic [7:0] LAST_ROW = 8'(IMG_H - 3);
    localparam logic [7:0] LAST_COL = 8'(IMG_W - 3);
`endif

    logic [2:0]        state;
    logic [1:0]        k_row;
    logic [1:0]        k_col;
    logic [ADDR_W-1:0] tap_row;
    logic [ADDR_W-1:0] tap_col;
    logic [ADDR_W-1:0] tap_addr;
    logic              last_tap;

`ifdef CONV_SEQ_PAD_EN
    logic tap_in;
    logic tap_in_q;

    // tap_row/tap_col carry a +1 offset here; 0 and IMG+1 are the padding ring
    always_comb begin
        tap_row  = ADDR_W'(win_row) + ADDR_W'(k_row);
        tap_col  = ADDR_W'(win_col) + ADDR_W'(k_col);
        tap_in   = (tap_row != '0) && (tap_row <= ADDR_W'(IMG_H)) &&
                   (tap_col != '0) && (tap_col <= ADDR_W'(IMG_W));
        tap_addr = (tap_row - ADDR_W'(1)) * ADDR_W'(IMG_W) + (tap_col - ADDR_W'(1));
    end

    assign mem_rd_en = (state == S_RD) && tap_in;
`else
    always_comb begin
        tap_row  = ADDR_W'(win_row) + ADDR_W'(k_row);
        tap_col  = ADDR_W'(win_col) + ADDR_W'(k_col);
        tap_addr = tap_row * ADDR_W'(IMG_W) + tap_col;
    end

    assign mem_rd_en = (state == S_RD);
`endif

    assign mem_addr  = mem_rd_en ? tap_addr : '0;
    assign out_valid = (state == S_STB);
    assign done      = (state == S_FIN);
    assign last_tap  = (k_row == 2'd2) && (k_col == 2'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            k_row    <= 2'd0;
            k_col    <= 2'd0;
            win_row  <= 8'd0;
            win_col  <= 8'd0;
            out_data <= 8'd0;
`ifdef CONV_SEQ_PAD_EN
            tap_in_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RD;
                        busy    <= 1'b1;
                        win_row <= 8'd0;
                        win_col <= 8'd0;
                        k_row   <= 2'd0;
                        k_col   <= 2'd0;
                    end
                end
                S_RD: begin
                    state <= S_CAP;
`ifdef CONV_SEQ_PAD_EN
                    tap_in_q <= tap_in;
`endif
                end
                S_CAP: begin
`ifdef CONV_SEQ_PAD_EN
                    out_data <= tap_in_q ? mem_rdata : 8'd0;
`else
                    out_data <= mem_rdata;
`endif
                    state <= S_STB;
                end
                S_STB: begin
                    if (last_tap) begin
                        k_row <= 2'd0;
                        k_col <= 2'd0;
                        state <= S_WAIT;
                    end else begin
                        if (k_col == 2'd2) begin
                            k_col <= 2'd0;
                            k_row <= k_row + 2'd1;
                        end else begin
                            k_col <= k_col + 2'd1;
                        end
                        state <= S_RD;
                    end
                end
                S_WAIT: begin
                    if (win_ack) begin
                        if (win_row == LAST_ROW && win_col == LAST_COL) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_RD;
                            if (win_col == LAST_COL) begin
                                win_col <= 8'd0;
                                win_row <= win_row + 8'd1;
                            end else begin
                                win_col <= win_col + 8'd1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer on a 5x4 image: table-driven window walk plus randomized
// runs against a window/tap reference model.
module tb_conv_window_sequencer;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = 10;
`ifdef CONV_SEQ_PAD_EN
    localparam int OFF = 1;
    localparam int NR  = H;
    localparam int NC  = W;
    int first_exp[9] = '{0, 0, 0, 0, 0, 1, 0, 5, 6};
    int last_exp[9]  = '{13, 14, 0, 18, 19, 0, 0, 0, 0};
`else
    localparam int OFF = 0;
    localparam int NR  = H - 2;
    localparam int NC  = W - 2;
    int first_exp[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int last_exp[9]  = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'd0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          win_ack = 1'b0;
    logic [7:0]    win_row;
    logic [7:0]    win_col;

    conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .win_ack(win_ack),
        .win_row(win_row), .win_col(win_col)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:W*H-1];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

    int vectors = 0;
    int miscompares = 0;
    int got_bytes[9];

    typedef struct {
        int ack_dly;
        int exp_row;
        int exp_col;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: tap k of window (r,c) sits at kernel position (k/3, k%3) from the top-left
    function automatic int tap_addr(input int r, input int c, input int k);
        int tr, tc;
        tr = r + k / 3 - OFF;
        tc = c + k % 3 - OFF;
        if (tr < 0 || tr >= H || tc < 0 || tc >= W) return -1;
        return tr * W + tc;
    endfunction

    function automatic int tap_byte(input int r, input int c, input int k);
        int a;
        a = tap_addr(r, c, k);
        return (a < 0) ? 0 : int'(ram[a]);
    endfunction

    // Observe one window from the current negedge up to its nstb-th strobe
    task automatic run_window(input int r, input int c, input int nstb, input bit inject);
        int addrs[$];
        int exp_a[$];
        int ns, last, t;
        ns = 0; last = -1; t = 0;
        for (int k = 0; k < nstb; k++) if (tap_addr(r, c, k) >= 0) exp_a.push_back(tap_addr(r, c, k));
        while (1) begin
            if (mem_rd_en) addrs.push_back(int'(mem_addr));
            if (out_valid) begin
                if (last >= 0) chk("strobe_gap", t - last, 3);
                last = t;
                chk("out_data", int'(out_data), tap_byte(r, c, ns));
                chk("win_row", int'(win_row), r);
                chk("win_col", int'(win_col), c);
                got_bytes[ns] = int'(out_data);
                ns++;
            end
            if (ns == nstb) break;
            if (t > 40) begin
                chk("strobe_timeout", ns, nstb);
                break;
            end
            if (inject) begin
                win_ack = 1'($urandom_range(0, 1));
                start   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            t++;
        end
        if (inject && ns == 9) win_ack = 1'b1;  // ack coinciding with the 9th strobe must be ignored
        else win_ack = 1'b0;
        start = 1'b0;
        chk("rd_count", addrs.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < addrs.size(); i++) chk("rd_addr", addrs[i], exp_a[i]);
    endtask

    // Hold off the ack for dly cycles, then pulse it
    task automatic ack_window(input int dly, input bit inject);
        int viol;
        viol = 0;
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            win_ack = 1'b0;
            start   = inject ? 1'($urandom_range(0, 1)) : 1'b0;
            if (out_valid || mem_rd_en || done) viol++;
        end
        chk("quiet_wait", viol, 0);
        win_ack = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        win_ack = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    // Sitting on the FIN cycle: check the done pulse and that a start here is dropped
    task automatic check_finish(input bit inject);
        int extra;
        extra = 0;
        chk("done_pulse", int'(done), 1);
        start = inject;
        @(negedge clk);
        start = 1'b0;
        chk("done_low", int'(done), 0);
        chk("busy_low", int'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy || mem_rd_en || out_valid) extra++;
        end
        chk("idle_after_done", extra, 0);
    endtask

    task automatic run_image(input bit inject, input int long_idx);
        pulse_start();
        for (int i = 0; i < NR * NC; i++) begin
            run_window(i / NC, i % NC, 9, inject);
            ack_window((i == long_idx) ? 50 : int'($urandom_range(1, 6)), inject);
        end
        check_finish(inject);
    endtask

    initial begin
        for (int a = 0; a < W * H; a++) ram[a] = 8'(a);
`ifdef CONV_SEQ_PAD_EN
        for (int i = 0; i < NR * NC; i++) tbl.push_back('{1 + (i % 5), i / NC, i % NC});
`else
        tbl.push_back('{4, 0, 0});
        tbl.push_back('{4, 0, 1});
        tbl.push_back('{1, 0, 2});
        tbl.push_back('{4, 1, 0});
        tbl.push_back('{7, 1, 1});
        tbl.push_back('{4, 1, 2});
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(mem_rd_en), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_row", int'(win_row), 0);
        chk("rst_col", int'(win_col), 0);
        rst_n = 1'b1;

        // Table-driven walk over all windows with RAM[a]=a
        pulse_start();
        for (int i = 0; i < tbl.size(); i++) begin
            run_window(tbl[i].exp_row, tbl[i].exp_col, 9, 1'b0);
            if (i == 0) for (int k = 0; k < 9; k++) chk("first_window_byte", got_bytes[k], first_exp[k]);
            if (i == tbl.size() - 1) for (int k = 0; k < 9; k++) chk("last_window_byte", got_bytes[k], last_exp[k]);
            ack_window(tbl[i].ack_dly, 1'b0);
        end
        check_finish(1'b0);

        // Long ack stall plus spurious start/ack pulses
        run_image(1'b1, 1);

        // Reset after the 4th strobe of the third window, then restart cleanly
        pulse_start();
        run_window(0, 0, 9, 1'b0);
        ack_window(4, 1'b0);
        run_window(0, 1, 9, 1'b0);
        ack_window(4, 1'b0);
        run_window(0, 2, 4, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_rd_en", int'(mem_rd_en), 0);
        chk("mid_rst_addr", int'(mem_addr), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_row", int'(win_row), 0);
        chk("mid_rst_col", int'(win_col), 0);
        chk("mid_rst_done", int'(done), 0);
        pulse_start();
        run_window(0, 0, 9, 1'b0);
        for (int k = 0; k < 9; k++) chk("restart_byte", got_bytes[k], first_exp[k]);
        ack_window(3, 1'b0);
        for (int i = 1; i < NR * NC; i++) begin
            run_window(i / NC, i % NC, 9, 1'b0);
            ack_window(2, 1'b0);
        end
        check_finish(1'b0);

        // Random image contents, random ack delays and spurious inputs
        for (int n = 0; n < 2; n++) begin
            for (int a = 0; a < W * H; a++) ram[a] = 8'($urandom);
            run_image(1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Controller that walks a stored 8-bit image in raster order and feeds each 3x3 convolution window, one byte per strobe, into the 9-byte window-assembly bridge.
- The bridge captures a byte on each 0->1 edge of its valid input, so this block guarantees a single-cycle valid pulse per byte with valid low in between.
- Sits between the on-chip image RAM (synchronous read port) and the bridge/convolution engine.
- Waits for a per-window acknowledge before issuing the next window.

Parameters:
- IMG_W, 28, image width in pixels (>=3)
- IMG_H, 28, image height in pixels (>=3)
- ADDR_W, 10, image RAM address width; IMG_W*IMG_H <= 2**ADDR_W

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle request to process the whole image
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the last window is acknowledged
- mem_rd_en  output  1  RAM read enable
- mem_addr  output  ADDR_W  RAM read address
- mem_rdata  input  8  RAM data, valid the cycle after mem_rd_en
- out_data  output  8  byte to bridge
- out_valid  output  1  single-cycle strobe to bridge
- win_ack  input  1  pulse: current window consumed (bridge vector-valid or conv result)
- win_row  output  8  top row of the current window
- win_col  output  8  left column of the current window

Behaviour:
- Reset: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_data=0, out_valid=0, win_row=0, win_col=0. FSM goes to IDLE and the kernel index k=0. The bridge shares rst_n, so its byte count stays aligned. Reset mid-window aborts with no further strobes.
- FSM states: IDLE, RD, CAP, STB, WAIT_ACK, FIN.
- IDLE:
  - start=1 -> RD, busy<=1, win_row=win_col=0, k=0.
  - start while busy is ignored.
- RD: mem_rd_en=1, mem_addr=(win_row+k/3)*IMG_W + win_col + k%3 -> CAP.
- CAP: mem_rdata sampled into out_data -> STB.
- STB: out_valid=1 for exactly this cycle.
  - If k<8: k<=k+1 -> RD.
  - Else: k<=0 -> WAIT_ACK.
- Strobe timing: strobes are 3 cycles apart, with out_valid low for 2 cycles between strobes. out_data is held stable from CAP+1 until the next CAP.
- Byte order within a window: k=0..8 row-major (top-left first), so bridge slot k holds kernel tap (k/3, k%3).
- WAIT_ACK: hold all outputs and wait for win_ack=1. win_ack in any other state is ignored. win_ack in the same cycle as the 9th STB is not accepted; it must arrive at STB+1 or later.
- Advance on ack:
  - win_col<IMG_W-3: win_col+1.
  - Else win_col=0, win_row+1.
  - If win_row=IMG_H-3 and win_col=IMG_W-3: -> FIN.
  - Otherwise -> RD.
- FIN: done=1 for one cycle, busy<=0 -> IDLE. A start in the FIN cycle is ignored.
- Window count: (IMG_H-2)*(IMG_W-2). Latency per window is 27 cycles plus ack wait.
- Address arithmetic: ADDR_W bits, never exceeds IMG_W*IMG_H-1 (no wrap in normal mode).

Optional Feature:
- CONV_SEQ_PAD_EN defined: zero padding of 1 pixel on every border.
  - Windows cover centres (0..IMG_H-1, 0..IMG_W-1), giving IMG_H*IMG_W windows. win_row/win_col report the centre.
  - A tap outside the image suppresses mem_rd_en in RD and loads out_data=0 in CAP. Timing is unchanged (still 3 cycles/byte).
- Undefined: valid-only windows as above; no padding logic is present.

Test Plan (IMG_W=5, IMG_H=4, RAM[a]=a):
- Reset, then start pulse -> busy=1 next cycle; mem_addr sequence 0,1,2,5,6,7,10,11,12; out_data matches at each out_valid; exactly 9 single-cycle strobes, 3 cycles apart.
- Ack each window 4 cycles after its 9th strobe -> 6 windows; (win_row,win_col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); last window addresses 7..19 subset (7,8,9,12,13,14,17,18,19); done pulses once; busy=0 after.
- Withhold win_ack 50 cycles -> no strobes and no mem_rd_en while waiting; start and spurious ack pulses during RD/STB have no effect.
- Assert rst_n=0 after the 4th strobe of window 2 -> next cycle all outputs at reset values; a new start restarts at address 0 and the bridge emits a correct first vector.
- With CONV_SEQ_PAD_EN -> 20 windows; first window bytes 0,0,0,0,0,1,0,5,6 with mem_rd_en only on 4 taps; last window bytes 13,14,0,18,19,0,0,0,0.
